// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register bank: FSM states, the write
// direction flag and the frame-width calculation.
package spi_reg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam logic SPI_WRITE = 1'b1;

   function automatic int frame_width(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, followed by a history
// flop that yields single-cycle rise/fall pulses on the synchronised value.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   // Chain resets low so a line already low at reset release never looks
   // like a falling edge; only a real high->low sequence produces one.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign dout = sync_q[SYNC_STAGES-1];
   assign rise = dout & ~hist_q;
   assign fall = ~dout & hist_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing NUM_REGS registers; writes commit on CS_N
// release. Define SPI_REG_BANK_READ_EN to build the CIPO read-back path.
module spi_reg_bank
   import spi_reg_pkg::*;
#(
   parameter int NUM_REGS    = 5,
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sclk,
   input  logic                         cs_n,
   input  logic                         copi,
   output logic                         cipo,
   output logic                         cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0]   regs_o,
   output logic [NUM_REGS-1:0]          wr_strobe_o,
   output logic                         frame_err_o
);

   localparam int FRAME_W = frame_width(ADDR_W, DATA_W);
   localparam int CNT_W   = $clog2(FRAME_W + 2);

   localparam logic [CNT_W-1:0]  CNT_HDR    = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_W + 1);
   localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

   logic sclk_s_unused, sclk_rise, sclk_fall;
   logic cs_s_unused, cs_rise, cs_fall;
   logic copi_s, copi_rise_unused, copi_fall_unused;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst(rst), .din(sclk),
      .dout(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .rst(rst), .din(cs_n),
      .dout(cs_s_unused), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
      .clk(clk), .rst(rst), .din(copi),
      .dout(copi_s), .rise(copi_rise_unused), .fall(copi_fall_unused)
   );

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [FRAME_W-1:0]  shift_in;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];

   logic                f_rw;
   logic [ADDR_W-1:0]   f_addr;
   logic [DATA_W-1:0]   f_data;
   logic                addr_ok;

   assign f_rw    = shift_in[FRAME_W-1];
   assign f_addr  = shift_in[FRAME_W-2 -: ADDR_W];
   assign f_data  = shift_in[DATA_W-1:0];
   assign addr_ok = ({1'b0, f_addr} < NUM_REGS_L);

   // Frame FSM: shift on sclk rise, decide on cs_n rise so the register
   // update and strobe are visible during the COMMIT cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         shift_in    <= '0;
         wr_strobe_o <= '0;
         frame_err_o <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         wr_strobe_o <= '0;
         frame_err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state    <= SHIFT;
                  cnt      <= '0;
                  shift_in <= '0;
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  state <= COMMIT;
                  if (cnt != CNT_FULL) begin
                     frame_err_o <= 1'b1;
                  end else if (f_rw == SPI_WRITE && addr_ok) begin
                     for (int i = 0; i < NUM_REGS; i++) begin
                        if (f_addr == ADDR_W'(i)) begin
                           regs_q[i]      <= f_data;
                           wr_strobe_o[i] <= 1'b1;
                        end
                     end
                  end
               end else if (sclk_rise) begin
                  shift_in <= {shift_in[FRAME_W-2:0], copi_s};
                  if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
               end
            end
            COMMIT: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
   end

`ifdef SPI_REG_BANK_READ_EN
   logic [ADDR_W:0]    hdr;
   logic [DATA_W-1:0]  rd_data;
   logic [DATA_W-1:0]  shift_out;

   // Header as it will stand once the current sclk rise shifts in copi.
   assign hdr = {shift_in[ADDR_W-1:0], copi_s};

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (hdr[ADDR_W-1:0] == ADDR_W'(i)) rd_data = regs_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cipo    <= 1'b0;
         cipo_oe <= 1'b0;
      end else if (state != SHIFT || cs_rise) begin
         cipo    <= 1'b0;
         cipo_oe <= 1'b0;
      end else if (sclk_rise && cnt == CNT_HDR && hdr[ADDR_W] != SPI_WRITE) begin
         shift_out <= rd_data;
         cipo_oe   <= 1'b1;
      end else if (sclk_fall && cipo_oe) begin
         cipo      <= shift_out[DATA_W-1];
         shift_out <= shift_out << 1;
      end
   end
`else
   logic rd_unused;
   assign rd_unused = sclk_fall;
   assign cipo      = 1'b0;
   assign cipo_oe   = 1'b0;
`endif

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI mode-0 peripheral exposing a bank of NUM_REGS configuration registers to the chip core, successor to the fixed five-register write-only receiver. It oversamples SCLK/COPI/CS_N in the `clk` domain, decodes 1 R/W bit + ADDR_W address bits + DATA_W data bits per frame, and commits writes atomically on CS_N release. With the read option compiled in, it also serves register reads on CIPO. It drives the PWM/output-enable registers consumed downstream.

## Interface
Parameters:
- NUM_REGS, 5, number of registers (1..2^ADDR_W)
- ADDR_W, 7, address field width
- DATA_W, 8, register/data field width
- SYNC_STAGES, 2, synchroniser flops before edge detect (≥2)

Ports:
- clk  in  1  system clock; sole clock domain
- rst  in  1  synchronous, active-high reset
- sclk  in  1  SPI clock, asynchronous
- cs_n  in  1  SPI chip select, active low, asynchronous
- copi  in  1  SPI data in, asynchronous
- cipo  out  1  SPI data out (0 when not driving)
- cipo_oe  out  1  CIPO output enable
- regs_o  out  NUM_REGS*DATA_W  register contents, reg i at [i*DATA_W +: DATA_W]
- wr_strobe_o  out  NUM_REGS  one-cycle pulse on the cycle reg i updates
- frame_err_o  out  1  one-cycle pulse when a frame is discarded

## Operation
- FRAME_W = 1+ADDR_W+DATA_W; bit order MSB first: [FRAME_W-1]=R/W (1=write), then address, then data.
- Each input passes SYNC_STAGES flops plus one history flop; edges detected on synchronised values only.
- FSM: IDLE -> SHIFT on synchronised cs_n falling edge; SHIFT samples copi on each synchronised sclk rising edge, bit counter increments; SHIFT -> COMMIT on cs_n rising edge; COMMIT -> IDLE after one cycle.
- COMMIT: write accepted only if count == FRAME_W, R/W=1, address < NUM_REGS; target register loads data, its strobe pulses.
- Count != FRAME_W (short or overrun, counter saturates at FRAME_W+1): frame discarded, frame_err_o pulses.
- Address ≥ NUM_REGS: write ignored silently, no error.
- sclk edges while cs_n high ignored. cs_n low at reset release: stays IDLE until a full cs_n high->low sequence.
- Read (option): after 1+ADDR_W bits with R/W=0, data snapshot of addressed reg (0 if out of range) loaded into shift-out register; cipo_oe=1 for rest of frame; next bit presented on each synchronised sclk falling edge. Reads never modify registers.

## Timing
- Reset: regs_o=0, wr_strobe_o=0, frame_err_o=0, cipo=0, cipo_oe=0, FSM=IDLE, counters cleared. Reset mid-frame aborts frame, no commit.
- Input-to-edge-detect latency: SYNC_STAGES+1 clk cycles.
- regs_o update and wr_strobe_o: 1 cycle after cs_n rising edge detected (COMMIT cycle).
- cipo change: 1 cycle after detected sclk falling edge; reads require f_clk ≥ 8·f_sclk, writes f_clk ≥ 4·f_sclk.
- cipo_oe drops the cycle cs_n rising edge is detected.
- Back-to-back frames: cs_n high for ≥ SYNC_STAGES+3 clk cycles.

## Configuration
- SPI_REG_BANK_READ_EN defined: read path, shift-out register and cipo/cipo_oe logic present as above.
- Undefined: cipo and cipo_oe tied 0; R/W=0 frames of correct length discarded without frame_err_o.

## Structure
- Package spi_reg_pkg: FSM state enum (IDLE, SHIFT, COMMIT), SPI_WRITE=1'b1 constant, frame-width function.
- Sub-module spi_sync_edge (SYNC_STAGES synchroniser + rise/fall pulses), instantiated for sclk, cs_n, copi (copi edges unused).

## Test plan
- Reset, write frame R/W=1 addr 0x04 data 0xA5 -> regs reg4=0xA5, wr_strobe_o[4] single pulse, others 0.
- Write addr 0x02 data 0x3C, then 15-bit frame to addr 0x02 data 0xFF -> reg2 stays 0x3C, frame_err_o pulses once.
- 17-bit frame -> discarded, frame_err_o pulse; write to addr 0x10 (NUM_REGS=5) -> no change, no error.
- READ_EN: write reg1=0x96, read addr 0x01 -> cipo shifts 1,0,0,1,0,1,1,0 during data phase, cipo_oe high only then; read addr 0x7F -> all zeros.
- Assert rst after 10 bits of a write -> all regs 0, cs_n release produces no strobe; next frame accepted normally.
